dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder for the RV32I core's load/store port, the slave end of the data access (address, write data, read data) the datapath issues. It accepts one request at a time over a valid/ready handshake and performs a word-organised RAM access after a programmable number of wait states. It handles byte/halfword lane steering and load sign/zero extension per funct3, and returns read data plus an error flag. It replaces the zero-latency combinational data memory when the core moves to a stalling/multicycle memory interface.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the RAM (power of two, >= 4)
LATENCY, 1, wait-state cycles between request accept and the access (0..15)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 of the load/store instruction
req_addr  input  32  byte address (core ALUResult)
req_wdata  input  32  store data, right-aligned (core WriteData)
rsp_valid  output  1  response present
rsp_ready  input  1  core consumes response
rsp_rdata  output  32  load result, extended; 0 for stores and errors
rsp_err  output  1  misaligned, out-of-range or illegal funct3

Behaviour:
- Reset (sync, high): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture we/funct3/addr/wdata. Go to WAIT with counter=LATENCY-1 if LATENCY>0, else go directly to RESP.
- WAIT: req_ready=0. Decrement counter. When counter==0, go to RESP.
- Access cycle: the clock edge entering RESP. The RAM is written, or read and extended into rsp_rdata, and rsp_err is registered. rsp_valid=1 from the next cycle.
- RESP: rsp_valid=1, req_ready=0. rsp_rdata/rsp_err are held stable until rsp_valid&&rsp_ready, then go to IDLE with rsp_valid=0.
- No back-to-back acceptance. Throughput is one request per LATENCY+2 cycles minimum.
- Latency: accept edge to rsp_valid high is LATENCY+1 cycles.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Byte lane = addr[1:0].
- Out of range: addr >= 4*DEPTH_WORDS sets err.
- Store funct3 legality: 000 sb, 001 sh, 010 sw are legal; others set err.
- Load funct3 legality: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu are legal; others set err.
- Misalignment: halfword with addr[0]=1 sets err. Word with addr[1:0]!=0 sets err.
- Stores: byte enables are derived from size and lane, and wdata is replicated into the lanes (sb: wdata[7:0] into lane addr[1:0]; sh: wdata[15:0] into half addr[1]). Unselected bytes are unchanged. rsp_rdata=0.
- Loads: the selected byte/half is shifted to bit 0. lb/lh sign-extend; lbu/lhu zero-extend.
- On err: no RAM write, rsp_rdata=0, rsp_err=1. The handshake completes normally.
- Reset mid-operation (WAIT or RESP): abort to IDLE. A store still in WAIT is never written; one already in RESP has completed. The pending response is discarded.
- Inputs are ignored outside IDLE. req_* may change freely after acceptance.

Test Plan:
- Reset then sw 0xDEADBEEF @0x10, then lw @0x10, LATENCY=1 -> rsp_valid 2 cycles after each accept; lw returns 0xDEADBEEF, err=0; store rsp_rdata=0.
- Following the above, sb 0x80 @0x13, then lb/lbu/lw @0x13/0x13/0x10 -> 0xFFFFFF80, 0x00000080, 0x80ADBEEF.
- sh 0x1234 @0x12, then lh/lhu @0x12 -> 0x00001234 both; then sh 0xF00D @0x12 and lh @0x12 -> 0xFFFFF00D; lw @0x10 -> 0xF00DBEEF.
- lh @0x11, sw @0x12, lw @0x1000 (DEPTH_WORDS=1024), load funct3=011 -> each err=1, rdata=0; lw @0x10 afterwards still 0xF00DBEEF.
- rsp_ready held low 3 cycles in RESP with LATENCY=3 -> rsp_valid and rdata stable, req_ready=0, and a new req_valid is ignored; accept occurs only after the rsp handshake.
- sw 0x11111111 @0x20 accepted with LATENCY=4, reset asserted during WAIT -> next cycle req_ready=1, rsp_valid=0; lw @0x20 returns the prior value 0x00000000 (pre-initialised).

Source files
------------

// File: rtl/dmem_responder.sv
// Purpose: RV32I data-memory slave with lane steering, load extension and error flagging over a word RAM.
// Latency: response valid LATENCY+1 cycles after the accept cycle; one request in flight, LATENCY+2 cycles minimum per request.
// Backpressure: req_ready only in IDLE; rsp_rdata/rsp_err held stable while rsp_valid waits for rsp_ready.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;
  logic        access;

  logic        cap_we;
  logic [2:0]  cap_f3;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic        acc_we;
  logic [2:0]  acc_f3;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          oor, legal, mis, err;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   rword, shifted, ld;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Next-state logic: accept in IDLE, count wait states, release on response handshake.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_nxt = RESP;
            access    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          access    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so use the live request.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_f3    = req_funct3;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = cap_we;
      acc_f3    = cap_f3;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
    end
  end

  // Decode legality, byte enables, store replication and load extension for the access.
  always_comb begin
    word_idx = acc_addr[AW+1:2];
    lane     = acc_addr[1:0];
    oor      = |acc_addr[31:AW+2];
    if (acc_we) legal = acc_f3 inside {3'b000, 3'b001, 3'b010};
    else        legal = acc_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    mis = ((acc_f3[1:0] == 2'b01) && lane[0]) ||
          ((acc_f3[1:0] == 2'b10) && (lane != 2'b00));
    err = oor || !legal || mis;

    be = 4'b1111;
    wd = acc_wdata;
    case (acc_f3[1:0])
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{acc_wdata[15:0]}};
      end
      default: ;
    endcase

    rword   = mem[word_idx];
    shifted = rword >> {lane, 3'b000};
    case (acc_f3)
      3'b000:  ld = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  ld = rword;
      3'b100:  ld = {24'd0, shifted[7:0]};
      3'b101:  ld = {16'd0, shifted[15:0]};
      default: ld = 32'd0;
    endcase
  end

  // State, wait counter and registered response; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (access) begin
        rsp_err   <= err;
        rsp_rdata <= (err || acc_we) ? 32'd0 : ld;
      end
    end
  end

  // Request capture so the core may change req_* after acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= req_we;
      cap_f3    <= req_funct3;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
    end
  end

  // Byte-enabled RAM write; a reset on the access edge suppresses the store.
  always_ff @(posedge clk) begin
    if (!reset && access && acc_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed RV32I load/store sequence plus randomized traffic.
// Expected data comes from a byte-addressed memory model and the ISA load/store rules.
// Response hold, ignored requests during RESP and reset abort in WAIT are exercised.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mbytes [0:4*DEPTH-1];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory and RV32I legality rules.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] d, output logic e);
    int n;
    logic [31:0] v;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (we) e = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    e = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (addr >= 32'(4*DEPTH)) e = 1'b1;
    if (addr % n != 0) e = 1'b1;
    d = 32'd0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < n; i++) mbytes[addr + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mbytes[addr + i]) << (8*i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        d = v;
      end
    end
  endtask

  // One full transaction from an IDLE negedge back to IDLE, holding the response 'hold' cycles.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input int hold);
    logic [31:0] exp_d;
    logic        exp_e;
    int          cyc;
    model(we, f3, addr, wdata, exp_d, exp_e);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom; req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(LAT + 1));
    chk("rsp_rdata", rsp_rdata, exp_d);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_e});
    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      // A store to 0x10 presented while busy must be ignored.
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10;
      req_wdata = $urandom;
      @(negedge clk);
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_rdata", rsp_rdata, exp_d);
      chk("hold_err", {31'd0, rsp_err}, {31'd0, exp_e});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    for (int i = 0; i < 4*DEPTH; i++) mbytes[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);

    // Give the words used below known contents.
    for (int w = 0; w < 16; w++) xact(1'b1, 3'd2, 32'(4*w), 32'd0, 0);

    xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
    xact(1'b0, 3'd2, 32'h10, 32'd0, 0);
    xact(1'b1, 3'd0, 32'h13, 32'h00000080, 0);
    xact(1'b0, 3'd0, 32'h13, 32'd0, 0);
    xact(1'b0, 3'd4, 32'h13, 32'd0, 0);
    xact(1'b0, 3'd2, 32'h10, 32'd0, 0);
    xact(1'b1, 3'd1, 32'h12, 32'h00001234, 0);
    xact(1'b0, 3'd1, 32'h12, 32'd0, 0);
    xact(1'b0, 3'd5, 32'h12, 32'd0, 0);
    xact(1'b1, 3'd1, 32'h12, 32'h0000F00D, 0);
    xact(1'b0, 3'd1, 32'h12, 32'd0, 0);
    xact(1'b0, 3'd2, 32'h10, 32'd0, 0);
    // Error cases, with the response held to check stability and ignored requests.
    xact(1'b0, 3'd1, 32'h11, 32'd0, 3);
    xact(1'b1, 3'd2, 32'h12, 32'h55555555, 0);
    xact(1'b0, 3'd2, 32'h1000, 32'd0, 0);
    xact(1'b0, 3'd3, 32'h10, 32'd0, 0);
    xact(1'b1, 3'd4, 32'h10, 32'h66666666, 0);
    xact(1'b0, 3'd2, 32'h10, 32'd0, 3);

    // Reset during WAIT discards the store.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20;
    req_wdata = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (LAT + 2) @(negedge clk);
    chk("abort_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    xact(1'b0, 3'd2, 32'h20, 32'd0, 0);

    // Randomized traffic over the initialised region plus occasional out-of-range.
    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 63));
      xact(1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
